data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's req/gnt/rvalid data interface. Answers loads and stores from the MEM stage with a word-organised synchronous RAM.
- Wait states before grant are programmable, so the core's stall handling can be exercised.
- Used in the testbench top and the FPGA wrapper. Also usable on the instruction port with we_i tied low.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.
- GNT_DELAY, 0: idle cycles between req_i rising/being presented and gnt_o; range 0..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  request valid from core.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = store, 0 = load.
- be_i  in  4  byte enables; be_i[k] covers wdata_i[8k+7:8k].
- addr_i  in  32  byte address; bits [1:0] ignored.
- wdata_i  in  32  store data.
- rvalid_o  out  1  response valid, one cycle per granted request.
- rdata_o  out  32  load data, valid when rvalid_o.
- err_o  out  1  response is an error (out-of-range address), qualified by rvalid_o.

Behaviour:
- Reset (rst_i high, any cycle, async): gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0. FSM goes to IDLE and the wait counter clears. RAM contents are not reset.
- Reset mid-transaction: a pending (ungranted) request is dropped. A granted request whose rvalid has not yet issued produces no rvalid. A store that was granted before reset has already written.
- Master rule (verified by assertion, not corrected): once req_i is high, we_i/be_i/addr_i/wdata_i stay stable until gnt_o.
- Address decode: index = (addr_i - BASE_ADDR) >> 2. in_range = addr_i in [BASE_ADDR, BASE_ADDR + DEPTH*4).
- FSM states: IDLE, WAIT.
  - GNT_DELAY = 0:
    - gnt_o = req_i & ~rst_i, combinational, in IDLE. FSM stays in IDLE.
    - Back-to-back grants every cycle.
  - GNT_DELAY > 0, IDLE → WAIT:
    - On req_i, load the counter with GNT_DELAY-1. gnt_o=0.
  - GNT_DELAY > 0, in WAIT:
    - If the counter is nonzero, decrement it. gnt_o=0.
    - If the counter is zero and req_i is high, gnt_o=1 combinationally and go to IDLE.
    - Next request's delay starts in the following cycle, so the grant rate is one per GNT_DELAY+1 cycles.
  - req_i dropping while in WAIT (protocol violation): return to IDLE, no access, no rvalid.
- Access on a grant cycle N:
  - Store, in range: at edge N, the bytes with be_i[k]=1 are written; other bytes are kept.
  - Load, in range: RAM is read at edge N.
  - Out of range: no write.
- Response:
  - rvalid_o=1 in cycle N+1, for exactly one cycle per grant.
  - Load in range: rdata_o = word, all 4 bytes regardless of be_i; the core extracts the bytes. err_o=0.
  - Store in range: rdata_o=0, err_o=0.
  - Out of range: rdata_o=0, err_o=1.
  - When rvalid_o=0: rdata_o holds its last value and err_o=0.
- Ordering: responses are in grant order, with at most one outstanding. No backpressure on rvalid; the core always accepts.
- Read-after-write: a store granted in N followed by a load to the same word granted in N+1 returns the new data in N+2.
- be_i=4'b0000 store: no bytes change, normal rvalid.

Test Plan:
- GNT_DELAY=0, store addr 0x10, wdata 0xDEADBEEF, be 4'hF in cycle N, then load 0x10 in N+1:
  - gnt high in N and N+1.
  - rvalid in N+1 (rdata 0, err 0) and in N+2.
  - rdata 0xDEADBEEF in N+2.
- Byte merge:
  - Preload 0x11223344 at 0x20.
  - Store wdata 0xAABBCCDD, be 4'b0101.
  - Load 0x20 → rdata 0x11BB33DD.
- GNT_DELAY=3, load held from cycle 0:
  - gnt only in cycle 3.
  - rvalid in cycle 4.
  - Continuous req gives grants at cycles 3, 7, 11.
- Out of range, DEPTH=1024, BASE 0: store to 0x1000 → rvalid with err_o=1, rdata 0, word 0 unchanged.
- Reset mid-operation, GNT_DELAY=0:
  - Load granted in N, rst_i pulsed high during N+1 before the edge.
  - rvalid_o/gnt_o go to 0 immediately and no rvalid is issued.
  - Previously stored words still read correctly after reset.
- Protocol violation, GNT_DELAY=2: req drops after 1 cycle → no gnt, no rvalid, FSM in IDLE, and the next request is granted 2 cycles after it is raised.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering the core's req/gnt/rvalid port, with programmable pre-grant wait states.
// Latency: grant after GNT_DELAY idle cycles (combinational when 0); response one cycle after the grant.
// Backpressure: only via withheld gnt_o; rvalid_o is never stalled and at most one response is outstanding.
module data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_DELAY = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
  localparam logic [3:0]  DLY_M1 = (GNT_DELAY == 0) ? 4'd0 : 4'(GNT_DELAY - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt;
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH];

  // Base-relative decode; an address below BASE_ADDR wraps to a huge offset
  // and therefore also fails the span compare.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = ({1'b0, offset} < SPAN);
  assign idx      = offset[AW+1:2];
  assign gnt_o    = gnt;

  // Grant FSM: wait-state counting and combinational grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    if (GNT_DELAY == 0) begin
      gnt     = req_i & ~rst_i;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            state_d = ST_WAIT;
            cnt_d   = DLY_M1;
          end
        end
        ST_WAIT: begin
          if (!req_i) begin
            // Master withdrew its request: abandon it without any access.
            state_d = ST_IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            gnt     = ~rst_i;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte-masked store into the RAM on an in-range granted write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Response: one rvalid per grant; rdata only carries load data and otherwise holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= 32'h0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= gnt;
      err_o    <= gnt & ~in_range;
      if (gnt) rdata_o <= (!we_i && in_range) ? mem[idx] : 32'h0;
    end
  end

`ifndef SYNTHESIS
  // Request fields must not change while a request waits for its grant.
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_i && !gnt_o) |=> (!req_i || $stable({we_i, be_i, addr_i, wdata_i})));
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: random traffic against a transaction-level memory model,
// plus directed wait-state, protocol-violation and reset scenarios on separately parameterised instances.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance with zero wait states, default depth and base.
  logic        req0, we0, gnt0, rvalid0, err0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0, rdata0;
  // Instance with three wait states, small RAM at a high base.
  logic        req3, we3, gnt3, rvalid3, err3;
  logic [3:0]  be3;
  logic [31:0] addr3, wdata3, rdata3;
  // Instance with two wait states for the withdrawn-request scenario.
  logic        req2, we2, gnt2, rvalid2, err2;
  logic [3:0]  be2;
  logic [31:0] addr2, wdata2, rdata2;

  data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .GNT_DELAY(0)) u_d0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .gnt_o(gnt0), .we_i(we0), .be_i(be0),
    .addr_i(addr0), .wdata_i(wdata0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0));

  data_mem_responder #(.DEPTH(64), .BASE_ADDR(32'h8000_0000), .GNT_DELAY(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .gnt_o(gnt3), .we_i(we3), .be_i(be3),
    .addr_i(addr3), .wdata_i(wdata3), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3));

  data_mem_responder #(.DEPTH(16), .BASE_ADDR(32'h0), .GNT_DELAY(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .gnt_o(gnt2), .we_i(we2), .be_i(be2),
    .addr_i(addr2), .wdata_i(wdata2), .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model for the zero-wait instance: word array plus the response
  // expected in the next cycle.
  logic [31:0] m [1024];
  logic        ev, ee;
  logic [31:0] erd;

  // One clock cycle on the zero-wait instance: present a request (or none),
  // check last cycle's response and this cycle's grant, then update the model.
  task automatic cyc(input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    logic [9:0]  wi;
    req0 = r; we0 = w; be0 = b; addr0 = a; wdata0 = d;
    @(negedge clk);
    chk("d0_rvalid", {31'h0, rvalid0}, {31'h0, ev});
    chk("d0_rdata", rdata0, erd);
    chk("d0_err", {31'h0, err0}, {31'h0, ee});
    chk("d0_gnt", {31'h0, gnt0}, {31'h0, r});
    ev = r;
    ee = 1'b0;
    if (r) begin
      off = a;
      if (off < 32'd4096) begin
        wi = off[11:2];
        if (w) begin
          for (int k = 0; k < 4; k++) if (b[k]) m[wi][8*k +: 8] = d[8*k +: 8];
          erd = 32'h0;
        end else begin
          erd = m[wi];
        end
      end else begin
        ee  = 1'b1;
        erd = 32'h0;
      end
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] ra, wv;
  int unsigned sel;

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
    req3 = 0; we3 = 0; be3 = 0; addr3 = 0; wdata3 = 0;
    req2 = 0; we2 = 0; be2 = 0; addr2 = 0; wdata2 = 0;
    ev = 1'b0; ee = 1'b0; erd = 32'h0;

    // Outputs held at their reset values.
    #12;
    chk("rst_gnt0", {31'h0, gnt0}, 32'h0);
    chk("rst_rvalid0", {31'h0, rvalid0}, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_err0", {31'h0, err0}, 32'h0);
    chk("rst_rvalid3", {31'h0, rvalid3}, 32'h0);
    chk("rst_rdata3", rdata3, 32'h0);
    chk("rst_rvalid2", {31'h0, rvalid2}, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fill the model-tracked low words.
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b1, 4'hF, 32'(i) * 4, $urandom);

    // Store then back-to-back load of the same word.
    cyc(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("raw_data", rdata0, 32'hDEADBEEF);

    // Byte merge.
    cyc(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
    cyc(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    cyc(1'b1, 1'b0, 4'h1, 32'h20, 32'h0);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("merge_data", rdata0, 32'h11BB33DD);

    // Out-of-range store at the first address past the RAM; word 0 untouched.
    cyc(1'b1, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
    cyc(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    // Empty byte-enable store leaves the word alone.
    cyc(1'b1, 1'b1, 4'h0, 32'h30, 32'h12345678);
    cyc(1'b1, 1'b0, 4'hF, 32'h30, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0)      ra = 32'h0000_1000;
      else if (sel == 1) ra = 32'hFFFF_FFFC;
      else if (sel == 2) ra = 32'h0010_0000 + 32'($urandom_range(0, 255));
      else               ra = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), ra, $urandom);
    end
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Three wait states with a continuously held request.
    wv = $urandom;
    for (int c = 0; c <= 12; c++) begin
      req3 = (c <= 11);
      we3  = (c <= 3);
      be3  = 4'hF;
      addr3 = (c <= 7) ? 32'h8000_0008 : 32'h8000_0100;
      wdata3 = (c <= 3) ? wv : 32'h0;
      @(negedge clk);
      chk($sformatf("d3_gnt_c%0d", c), {31'h0, gnt3}, {31'h0, (c == 3 || c == 7 || c == 11)});
      chk($sformatf("d3_rvalid_c%0d", c), {31'h0, rvalid3}, {31'h0, (c == 4 || c == 8 || c == 12)});
      if (c == 4) begin
        chk("d3_store_rdata", rdata3, 32'h0);
        chk("d3_store_err", {31'h0, err3}, 32'h0);
      end
      if (c == 8) begin
        chk("d3_load_rdata", rdata3, wv);
        chk("d3_load_err", {31'h0, err3}, 32'h0);
      end
      if (c == 12) begin
        chk("d3_oor_rdata", rdata3, 32'h0);
        chk("d3_oor_err", {31'h0, err3}, 32'h1);
      end
      @(posedge clk); #1;
    end

    // Two wait states: request withdrawn after one cycle, then a fresh one at cycle 5.
    for (int c = 0; c <= 9; c++) begin
      req2 = (c == 0) || (c >= 5 && c <= 7);
      we2 = 1'b1; be2 = 4'hF; addr2 = 32'h4; wdata2 = 32'h55AA_33CC;
      @(negedge clk);
      chk($sformatf("d2_gnt_c%0d", c), {31'h0, gnt2}, {31'h0, (c == 7)});
      chk($sformatf("d2_rvalid_c%0d", c), {31'h0, rvalid2}, {31'h0, (c == 8)});
      if (c == 8) chk("d2_err", {31'h0, err2}, 32'h0);
      @(posedge clk); #1;
    end
    req2 = 1'b0;

    // Reset while a granted load's response is due.
    cyc(1'b1, 1'b1, 4'hF, 32'h40, 32'h0BADCAFE);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    req0 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_rvalid", {31'h0, rvalid0}, 32'h0);
    chk("rstmid_rdata", rdata0, 32'h0);
    req0 = 1'b1;
    #1;
    chk("rstmid_gnt", {31'h0, gnt0}, 32'h0);
    req0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_no_rvalid", {31'h0, rvalid0}, 32'h0);
    @(posedge clk); #1;
    ev = 1'b0; ee = 1'b0; erd = 32'h0;
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    cyc(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    cyc(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 4'hF, 32'($urandom_range(0, 63)) * 4, 32'h0);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
